gc_response_tx: RTL and testbench
=================================

// Module: gc_response_tx
// PURPOSE
// - Response serializer for one emulated Gamecube controller port; downstream of the gc_controller request decoder, upstream of n_serial_bit_generator.
// - On a decoded request, streams the reply MSB-first: ID (24 bits), status (64 bits fetched one bit at a time from shared state RAM via the arbiter), or origins (80 bits); then requests a stop bit.
// - Status bits are prefetched, so RAM latency overlaps transmission of the previous bit.
// PARAMETERS
// - CONTROLLER_ID           24'h090000                  ID reply word
// - CONTROLLER_CALIBRATION  80'h00808080808000000202    origins reply word
// - ACK_TIMEOUT             255                          max cycles waiting for state_ack per bit
// PORTS
// - clk            in   1  clock
// - reset          in   1  asynchronous, active-high
// - start          in   1  1-cycle pulse: begin reply of type resp_type
// - resp_type      in   2  0=ID, 1=status, 2=origins, 3=reserved
// - abort          in   1  console began a new frame (rx_start); cancel reply
// - busy           out  1  reply in progress
// - done           out  1  1-cycle pulse after stop bit accepted
// - timeout_err    out  1  sticky: some state fetch timed out; cleared by next start
// - state_addr     out  6  status bit index, 0 = MSB of byte 0
// - state_request  out  1  fetch request to the RAM arbiter
// - state_data     in   1  fetched bit, valid while state_ack is high
// - state_ack      in   1  fetch complete
// - tx_busy        in   1  bit generator is sending
// - tx_data        out  1  bit to send, valid with tx_strobe
// - tx_strobe      out  1  1-cycle pulse: generator accepts tx_data
// - tx_stop        out  1  1-cycle pulse: generator emits stop bit
// BEHAVIOUR
// - Reset: all outputs 0; FSM in IDLE; bit counter 0; timeout_err 0.
// - start accepted only in IDLE with resp_type<3; otherwise ignored (no done). Length L = 24/64/80.
// - States: IDLE -> LOAD -> (FETCH) -> WAIT_TX -> SEND -> ... -> STOP -> DONE -> IDLE.
// - LOAD (1 cycle): latch type; ID/origins go to WAIT_TX with the word preloaded into a shift register; status goes to FETCH for bit 0.
// - FETCH: state_request=1 with state_addr=bit index held stable; on the first cycle with state_ack=1, capture state_data; request drops next cycle.
// - Timeout: ACK_TIMEOUT cycles without ack -> use bit value 0, set timeout_err, continue.
// - WAIT_TX: wait for tx_busy=0 and current bit valid. SEND: tx_strobe=1 for exactly 1 cycle.
// - After any strobe, ignore tx_busy for 1 cycle (generator latency); status mode issues the fetch of bit n+1 in the same cycle that bit n is strobed.
// - After bit L-1 strobe: STOP waits tx_busy=0 (after the 1-cycle guard), pulses tx_stop 1 cycle, then waits tx_busy=0 again; DONE pulses done 1 cycle.
// - busy=1 from the cycle after an accepted start through the DONE cycle inclusive.
// - Bit counter is 7 bits, counts 0..L-1 and never wraps; state_addr = counter[5:0] (status only, <64).
// - abort in any non-IDLE state: next cycle IDLE, state_request=0, no further strobe/stop, no done; a pending ack is discarded. abort takes priority over start in the same cycle.
// - start coincident with DONE: ignored (still busy).
// - Reset mid-reply: immediate return to reset state; no stop bit is emitted.
// STRUCTURE
// - Shared package gc_pkg: resp_type codes (GC_RESP_ID/STATUS/ORIGINS), default ID and calibration constants, reply lengths.
// - Sub-module gc_state_fetch: the request/ack/timeout handshake for one bit (addr in, bit out, valid/timeout flags).
// - Top module: FSM, 80-bit shift register, bit counter, tx handshake.
// TESTING
// - ID: start, type 0, generator model with 1-cycle busy -> 24 strobes with 0x090000 MSB-first, 1 tx_stop, 1 done, state_request never asserted.
// - Status: RAM model holding 0x00,0x80,0x12,0x34,0x80,0x80,0x00,0x00, ack after 3 cycles -> 64 strobes reproduce the bytes MSB-first; addr k requested before bit k strobes.
// - Origins: type 2 -> 80 bits 0x00808080808000000202, then stop, then done.
// - Timeout: ack never asserted for addr 5, ACK_TIMEOUT=16 -> bit 5 sent as 0, timeout_err=1; next start clears it.
// - Abort at bit 30 of status -> no further strobes/stop/done; busy=0 next cycle; an immediate new ID start replies correctly.
// - start while busy and resp_type=3 in IDLE -> ignored; async reset mid-stream -> all outputs 0 at once.

Source files
------------

// File: rtl/gc_pkg.sv
// rtl/gc_pkg.sv - shared reply types, default reply words and FSM encoding for the Gamecube responder
package gc_pkg;

    typedef enum logic [1:0] {
        GC_RESP_ID      = 2'd0,
        GC_RESP_STATUS  = 2'd1,
        GC_RESP_ORIGINS = 2'd2,
        GC_RESP_RSVD    = 2'd3
    } gc_resp_e;

    localparam logic [23:0] GC_DEFAULT_ID          = 24'h090000;
    localparam logic [79:0] GC_DEFAULT_CALIBRATION = 80'h00808080808000000202;

    localparam logic [6:0] GC_LEN_ID      = 7'd24;
    localparam logic [6:0] GC_LEN_STATUS  = 7'd64;
    localparam logic [6:0] GC_LEN_ORIGINS = 7'd80;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FETCH,
        ST_WAIT_TX,
        ST_SEND,
        ST_STOP_WAIT,
        ST_STOP_SEND,
        ST_STOP_DRAIN,
        ST_DONE
    } gc_tx_state_e;

    // Reply length in bits; the reserved code never reaches the serializer.
    function automatic logic [6:0] gc_reply_len(input gc_resp_e t);
        case (t)
            GC_RESP_ID:      return GC_LEN_ID;
            GC_RESP_STATUS:  return GC_LEN_STATUS;
            GC_RESP_ORIGINS: return GC_LEN_ORIGINS;
            default:         return 7'd0;
        endcase
    endfunction

endpackage

// File: rtl/gc_state_fetch.sv
// rtl/gc_state_fetch.sv - one-bit request/ack/timeout handshake towards the state RAM arbiter
module gc_state_fetch #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       cancel,
    input  logic [5:0] addr,
    input  logic       state_data,
    input  logic       state_ack,
    output logic       state_request,
    output logic [5:0] state_addr,
    output logic       bit_value,
    output logic       bit_valid,
    output logic       timeout
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    logic          req_q, req_d;
    logic [5:0]    addr_q, addr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bit_q, bit_d;
    logic          valid_q, valid_d;
    logic          timeout_q, timeout_d;

    // Hold the request until ack or until the wait budget runs out; a late ack after cancel is ignored.
    always_comb begin
        req_d     = req_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        if (cancel) begin
            req_d   = 1'b0;
            valid_d = 1'b0;
            cnt_d   = '0;
            addr_d  = '0;
        end else if (start) begin
            req_d   = 1'b1;
            addr_d  = addr;
            cnt_d   = '0;
            valid_d = 1'b0;
        end else if (req_q) begin
            if (state_ack) begin
                bit_d   = state_data;
                valid_d = 1'b1;
                req_d   = 1'b0;
            end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
                bit_d     = 1'b0;
                valid_d   = 1'b1;
                req_d     = 1'b0;
                timeout_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Handshake state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q     <= 1'b0;
            addr_q    <= '0;
            cnt_q     <= '0;
            bit_q     <= 1'b0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            req_q     <= req_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign state_request = req_q;
    assign state_addr    = addr_q;
    assign bit_value     = bit_q;
    assign bit_valid     = valid_q;
    assign timeout       = timeout_q;

endmodule

// File: rtl/gc_response_tx.sv
// rtl/gc_response_tx.sv - serializes ID/status/origins replies MSB-first to the bit generator
module gc_response_tx
    import gc_pkg::*;
#(
    parameter logic [23:0] CONTROLLER_ID          = GC_DEFAULT_ID,
    parameter logic [79:0] CONTROLLER_CALIBRATION = GC_DEFAULT_CALIBRATION,
    parameter int          ACK_TIMEOUT            = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] resp_type,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       timeout_err,
    output logic [5:0] state_addr,
    output logic       state_request,
    input  logic       state_data,
    input  logic       state_ack,
    input  logic       tx_busy,
    output logic       tx_data,
    output logic       tx_strobe,
    output logic       tx_stop
);

    gc_tx_state_e state_q, state_d;
    gc_resp_e     type_q, type_d;
    logic [79:0]  shift_q, shift_d;
    logic [6:0]   count_q, count_d;
    logic         guard_q, guard_d;
    logic         timeout_err_q, timeout_err_d;

    logic         fetch_start, fetch_cancel;
    logic [5:0]   fetch_addr;
    logic         fetch_bit, fetch_valid, fetch_timeout;

    logic         is_status, cur_bit, bit_ready, tx_free;
    logic [6:0]   last_idx;

    assign is_status  = (type_q == GC_RESP_STATUS);
    assign cur_bit    = is_status ? fetch_bit : shift_q[79];
    assign bit_ready  = !is_status || fetch_valid;
    // The generator raises tx_busy one cycle after a strobe, so that cycle is not trusted.
    assign tx_free    = !guard_q && !tx_busy;
    assign last_idx   = gc_reply_len(type_q) - 7'd1;
    assign fetch_addr = count_d[5:0];

    gc_state_fetch #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_fetch (
        .clk          (clk),
        .reset        (reset),
        .start        (fetch_start),
        .cancel       (fetch_cancel),
        .addr         (fetch_addr),
        .state_data   (state_data),
        .state_ack    (state_ack),
        .state_request(state_request),
        .state_addr   (state_addr),
        .bit_value    (fetch_bit),
        .bit_valid    (fetch_valid),
        .timeout      (fetch_timeout)
    );

    // Reply FSM: next state, datapath updates and tx handshake outputs.
    always_comb begin
        state_d       = state_q;
        type_d        = type_q;
        shift_d       = shift_q;
        count_d       = count_q;
        guard_d       = 1'b0;
        timeout_err_d = timeout_err_q | fetch_timeout;
        fetch_start   = 1'b0;
        fetch_cancel  = 1'b0;
        busy          = (state_q != ST_IDLE);
        done          = 1'b0;
        tx_strobe     = 1'b0;
        tx_stop       = 1'b0;
        tx_data       = 1'b0;
        if (state_q != ST_IDLE && abort) begin
            state_d      = ST_IDLE;
            fetch_cancel = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !abort && resp_type != GC_RESP_RSVD) begin
                        type_d        = gc_resp_e'(resp_type);
                        count_d       = 7'd0;
                        timeout_err_d = 1'b0;
                        state_d       = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    case (type_q)
                        GC_RESP_ID: begin
                            shift_d = {CONTROLLER_ID, 56'd0};
                            state_d = ST_WAIT_TX;
                        end
                        GC_RESP_ORIGINS: begin
                            shift_d = CONTROLLER_CALIBRATION;
                            state_d = ST_WAIT_TX;
                        end
                        default: begin
                            fetch_start = 1'b1;
                            state_d     = ST_FETCH;
                        end
                    endcase
                end
                ST_FETCH: begin
                    if (fetch_valid) state_d = ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    if (tx_free && bit_ready) state_d = ST_SEND;
                end
                ST_SEND: begin
                    tx_strobe = 1'b1;
                    tx_data   = cur_bit;
                    guard_d   = 1'b1;
                    if (count_q == last_idx) begin
                        state_d = ST_STOP_WAIT;
                    end else begin
                        count_d     = count_q + 7'd1;
                        shift_d     = {shift_q[78:0], 1'b0};
                        fetch_start = is_status;
                        state_d     = ST_WAIT_TX;
                    end
                end
                ST_STOP_WAIT: begin
                    if (tx_free) state_d = ST_STOP_SEND;
                end
                ST_STOP_SEND: begin
                    tx_stop = 1'b1;
                    guard_d = 1'b1;
                    state_d = ST_STOP_DRAIN;
                end
                ST_STOP_DRAIN: begin
                    if (tx_free) state_d = ST_DONE;
                end
                ST_DONE: begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            type_q        <= GC_RESP_ID;
            shift_q       <= '0;
            count_q       <= '0;
            guard_q       <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            type_q        <= type_d;
            shift_q       <= shift_d;
            count_q       <= count_d;
            guard_q       <= guard_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_gc_response_tx.sv
// tb/tb_gc_response_tx.sv - directed self-checking bench for gc_response_tx
module tb_gc_response_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] resp_type = 2'd0;
    logic       abort = 1'b0;
    logic       busy, done, timeout_err;
    logic [5:0] state_addr;
    logic       state_request;
    logic       state_data = 1'b0;
    logic       state_ack = 1'b0;
    logic       tx_busy = 1'b0;
    logic       tx_data, tx_strobe, tx_stop;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [0:7];
    int          ack_delay = 3;
    int          never_addr = -1;
    int          gen_busy = 1;
    logic        check_order = 1'b0;

    int          req_run = 0;
    int          busy_cnt = 0;
    int          strobe_cnt = 0, stop_cnt = 0, done_cnt = 0, req_cnt = 0, ack_cnt = 0, order_err = 0;
    int          last_ack_addr = -1;
    logic        prev_req = 1'b0;
    logic [5:0]  prev_addr = 6'd0;
    logic [79:0] cap = '0;

    int sb = 0, pb = 0, db = 0, ab = 0, rb = 0;

    gc_response_tx #(
        .ACK_TIMEOUT(16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .resp_type    (resp_type),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .timeout_err  (timeout_err),
        .state_addr   (state_addr),
        .state_request(state_request),
        .state_data   (state_data),
        .state_ack    (state_ack),
        .tx_busy      (tx_busy),
        .tx_data      (tx_data),
        .tx_strobe    (tx_strobe),
        .tx_stop      (tx_stop)
    );

    always #5 clk = ~clk;

    // Monitor, bit-generator model and state RAM model, all evaluated mid-cycle.
    always @(negedge clk) begin
        if (reset) begin
            busy_cnt  = 0;
            tx_busy   = 1'b0;
            state_ack = 1'b0;
            req_run   = 0;
            prev_req  = 1'b0;
        end else begin
            if (tx_strobe) begin
                if (check_order && ((ack_cnt - ab) != (strobe_cnt - sb) + 1 || last_ack_addr != strobe_cnt - sb))
                    order_err++;
                cap = {cap[78:0], tx_data};
                strobe_cnt++;
            end
            if (tx_stop) stop_cnt++;
            if (done) done_cnt++;
            if (state_request) begin
                req_cnt++;
                if (prev_req && state_addr != prev_addr) order_err++;
            end
            prev_req  = state_request;
            prev_addr = state_addr;
            if (tx_strobe || tx_stop) busy_cnt = gen_busy;
            else if (busy_cnt > 0) busy_cnt--;
            tx_busy = (busy_cnt != 0);
            if (state_ack) begin
                state_ack = 1'b0;
                req_run   = 0;
            end else if (state_request) begin
                req_run++;
                if (req_run == ack_delay && int'(state_addr) != never_addr) begin
                    state_ack     = 1'b1;
                    state_data    = mem[state_addr[5:3]][3'd7 - state_addr[2:0]];
                    ack_cnt++;
                    last_ack_addr = int'(state_addr);
                end
            end else begin
                req_run = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        sb = strobe_cnt; pb = stop_cnt; db = done_cnt; ab = ack_cnt; rb = req_cnt;
    endtask

    task automatic do_start(input logic [1:0] t);
        @(negedge clk);
        start = 1'b1;
        resp_type = t;
        @(negedge clk);
        start = 1'b0;
        #1;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int n;
        n = 0;
        while (done_cnt == db && n < maxc) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(tag, done_cnt != db, 1'b1);
    endtask

    task automatic wait_strobes(input string tag, input int k, input int maxc);
        int n;
        n = 0;
        while (strobe_cnt - sb < k && n < maxc) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(tag, strobe_cnt - sb, k);
    endtask

    initial begin
        mem[0] = 8'h00; mem[1] = 8'h80; mem[2] = 8'h12; mem[3] = 8'h34;
        mem[4] = 8'h80; mem[5] = 8'h80; mem[6] = 8'h00; mem[7] = 8'h00;

        #1;
        chk("reset_outputs", {busy, done, timeout_err, state_addr, state_request, tx_data, tx_strobe, tx_stop}, 13'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy", busy, 1'b0);

        // ID reply
        snap();
        do_start(2'd0);
        chk("id_busy_after_start", busy, 1'b1);
        wait_done("id_done_seen", 2000);
        @(negedge clk); #1;
        chk("id_busy_after_done", busy, 1'b0);
        chk("id_strobes", strobe_cnt - sb, 24);
        chk("id_bits", cap[23:0], 24'h090000);
        chk("id_stops", stop_cnt - pb, 1);
        chk("id_dones", done_cnt - db, 1);
        chk("id_no_request", req_cnt - rb, 0);

        // Status reply with prefetched RAM bits
        snap();
        check_order = 1'b1;
        do_start(2'd1);
        wait_done("st_done_seen", 3000);
        check_order = 1'b0;
        chk("st_strobes", strobe_cnt - sb, 64);
        chk("st_bits", cap[63:0], 64'h0080123480800000);
        chk("st_order", order_err, 0);
        chk("st_stops", stop_cnt - pb, 1);
        chk("st_timeout_err", timeout_err, 1'b0);

        // Origins reply with a slower generator
        gen_busy = 3;
        snap();
        do_start(2'd2);
        wait_done("or_done_seen", 3000);
        chk("or_strobes", strobe_cnt - sb, 80);
        chk("or_bits", cap[79:0], 80'h00808080808000000202);
        chk("or_stops", stop_cnt - pb, 1);
        gen_busy = 1;

        // Fetch timeout on addr 5
        mem[0] = 8'hFF;
        never_addr = 5;
        snap();
        do_start(2'd1);
        wait_done("to_done_seen", 4000);
        chk("to_bits", cap[63:0], 64'hFB80123480800000);
        chk("to_timeout_err", timeout_err, 1'b1);
        never_addr = -1;
        mem[0] = 8'h00;
        snap();
        do_start(2'd0);
        chk("to_err_cleared", timeout_err, 1'b0);
        wait_done("to_id_done", 2000);

        // Abort during status bit 30, then an immediate ID reply
        snap();
        do_start(2'd1);
        wait_strobes("ab_reach_bit30", 31, 3000);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk("ab_busy_next", busy, 1'b0);
        chk("ab_request_low", state_request, 1'b0);
        do_start(2'd0);
        wait_done("ab_id_done", 2000);
        chk("ab_total_strobes", strobe_cnt - sb, 55);
        chk("ab_id_bits", cap[23:0], 24'h090000);
        chk("ab_stops", stop_cnt - pb, 1);
        chk("ab_dones", done_cnt - db, 1);

        // start while busy and start coincident with DONE are ignored
        snap();
        do_start(2'd0);
        repeat (10) @(negedge clk);
        start = 1'b1; resp_type = 2'd2;
        @(negedge clk);
        start = 1'b0;
        begin
            int n;
            n = 0;
            while (!done && n < 2000) begin
                @(negedge clk);
                n++;
            end
        end
        start = 1'b1; resp_type = 2'd0;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("bz_busy_after_done", busy, 1'b0);
        repeat (30) @(negedge clk);
        #1;
        chk("bz_strobes", strobe_cnt - sb, 24);
        chk("bz_bits", cap[23:0], 24'h090000);
        chk("bz_dones", done_cnt - db, 1);

        // Reserved type in IDLE is ignored
        snap();
        do_start(2'd3);
        chk("rsv_busy", busy, 1'b0);
        repeat (20) @(negedge clk);
        chk("rsv_strobes", strobe_cnt - sb, 0);
        chk("rsv_dones", done_cnt - db, 0);

        // Asynchronous reset mid-stream
        snap();
        do_start(2'd1);
        wait_strobes("rst_reach_bit10", 10, 2000);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_outputs", {busy, done, timeout_err, state_addr, state_request, tx_data, tx_strobe, tx_stop}, 13'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (50) @(negedge clk);
        #1;
        chk("rst_no_stop", stop_cnt - pb, 0);
        chk("rst_no_done", done_cnt - db, 0);
        chk("rst_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
